ex_stage: RTL and testbench



---
 rtl/ex_stage_pkg.sv | 26 ++
 rtl/alu.sv | 33 +++
 rtl/ex_stage_div_iter.sv | 82 ++++++++
 rtl/ex_stage.sv | 127 ++++++++++++
 tb/tb_ex_stage.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_pkg.sv
// Shared widths, stall encoding, SPECIAL function codes and divider states for the EX stage.
package ex_stage_pkg;

    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 76;
    localparam int EX_TO_ID_WD  = 38;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_e;

endpackage

// File: rtl/alu.sv
// One-hot ALU: {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}.
module alu (
    input  logic [11:0] alu_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] result
);

    logic [31:0] add_r, sub_r, slt_r, sltu_r, sra_r;

    assign add_r  = src1 + src2;
    assign sub_r  = src1 - src2;
    assign slt_r  = {31'b0, $signed(src1) < $signed(src2)};
    assign sltu_r = {31'b0, src1 < src2};
    assign sra_r  = $unsigned($signed(src2) >>> src1[4:0]);

    always_comb begin
        result = '0;
        if (alu_op[11]) result = result | add_r;
        if (alu_op[10]) result = result | sub_r;
        if (alu_op[9])  result = result | slt_r;
        if (alu_op[8])  result = result | sltu_r;
        if (alu_op[7])  result = result | (src1 & src2);
        if (alu_op[6])  result = result | ~(src1 | src2);
        if (alu_op[5])  result = result | (src1 | src2);
        if (alu_op[4])  result = result | (src1 ^ src2);
        if (alu_op[3])  result = result | (src2 << src1[4:0]);
        if (alu_op[2])  result = result | (src2 >> src1[4:0]);
        if (alu_op[1])  result = result | sra_r;
        if (alu_op[0])  result = result | {src2[15:0], 16'b0};
    end

endmodule

// File: rtl/ex_stage_div_iter.sv
// Restoring shift-subtract divider: one quotient bit per BUSY cycle, result held in DONE until acked.
module div_iter
    import ex_stage_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        ack,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int CNT_W = $clog2(DIV_ITER);

    div_state_e state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0] den, rem, quo, diff;
    logic [32:0] partial;
    logic neg_q, neg_r, dz, fits;

    always_ff @(posedge clk) begin
        if (rst) state <= DIV_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (start) state_nxt = DIV_BUSY;
            DIV_BUSY: if (cnt == CNT_W'(DIV_ITER - 1)) state_nxt = DIV_DONE;
            DIV_DONE: if (ack) state_nxt = DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    // rem < den is invariant, so the 33-bit partial only needs its low word after a subtract
    assign partial = {rem, quo[31]};
    assign fits    = partial >= {1'b0, den};
    assign diff    = partial[31:0] - den;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            den   <= '0;
            rem   <= '0;
            quo   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz    <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: if (start) begin
                    cnt   <= '0;
                    rem   <= '0;
                    quo   <= (is_signed && dividend[31]) ? ~dividend + 32'd1 : dividend;
                    den   <= (is_signed && divisor[31])  ? ~divisor + 32'd1  : divisor;
                    neg_q <= is_signed & (dividend[31] ^ divisor[31]);
                    neg_r <= is_signed & dividend[31];
                    dz    <= divisor == 32'd0;
                end
                DIV_BUSY: begin
                    rem <= fits ? diff : partial[31:0];
                    quo <= {quo[30:0], fits};
                    cnt <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done      = state == DIV_DONE;
    // a zero divisor leaves rem = |dividend|, so the sign fix restores the dividend exactly
    assign quotient  = dz ? 32'hFFFF_FFFF : (neg_q ? ~quo + 32'd1 : quo);
    assign remainder = neg_r ? ~rem + 32'd1 : rem;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, ALU, data-SRAM request, HI/LO with mult and iterative div.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
    output logic                    is_lw,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic                    stallreq_for_ex
);

    logic [ID_TO_EX_WD-1:0] bus_q;

    always_ff @(posedge clk) begin
        if (rst)                                        bus_q <= '0;
        else if (stall[2] == STOP && stall[3] == NO_STOP) bus_q <= '0;
        else if (stall[2] == NO_STOP)                   bus_q <= id_to_ex_bus;
    end

    logic [31:0] pc, inst, rdata1, rdata2;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2, ram_wen;
    logic        ram_en, rf_we, sel_rf_res;
    logic [4:0]  rf_waddr;

    assign {pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen,
            rf_we, rf_waddr, sel_rf_res, rdata1, rdata2} = bus_q;

    logic [31:0] src1, src2, alu_result, imm_sext, imm_zext;

    assign imm_sext = {{16{inst[15]}}, inst[15:0]};
    assign imm_zext = {16'b0, inst[15:0]};
    assign src1 = ({32{sel_src1[0]}} & rdata1)
                | ({32{sel_src1[1]}} & pc)
                | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});
    assign src2 = ({32{sel_src2[0]}} & rdata2)
                | ({32{sel_src2[1]}} & imm_sext)
                | ({32{sel_src2[2]}} & 32'd8)
                | ({32{sel_src2[3]}} & imm_zext);

    alu u_alu (
        .alu_op (alu_op),
        .src1   (src1),
        .src2   (src2),
        .result (alu_result)
    );

    // full SPECIAL decode, including the fields that must be zero for each form
    logic special, is_mfhi, is_mflo, is_mthi, is_mtlo, is_mult, is_multu, is_div, is_divu;
    logic [5:0] func;

    assign special  = inst[31:26] == 6'b0;
    assign func     = inst[5:0];
    assign is_mfhi  = special && inst[25:16] == 10'b0 && inst[10:6] == 5'b0 && func == FN_MFHI;
    assign is_mflo  = special && inst[25:16] == 10'b0 && inst[10:6] == 5'b0 && func == FN_MFLO;
    assign is_mthi  = special && inst[20:6] == 15'b0 && func == FN_MTHI;
    assign is_mtlo  = special && inst[20:6] == 15'b0 && func == FN_MTLO;
    assign is_mult  = special && inst[15:6] == 10'b0 && func == FN_MULT;
    assign is_multu = special && inst[15:6] == 10'b0 && func == FN_MULTU;
    assign is_div   = special && inst[15:6] == 10'b0 && func == FN_DIV;
    assign is_divu  = special && inst[15:6] == 10'b0 && func == FN_DIVU;

    logic        advance, div_done;
    logic [31:0] hi, lo, div_quo, div_rem;
    logic [63:0] prod_s, prod_u;

    assign advance = stall[2] == NO_STOP;
    assign prod_s  = {{32{rdata1[31]}}, rdata1} * {{32{rdata2[31]}}, rdata2};
    assign prod_u  = {32'b0, rdata1} * {32'b0, rdata2};

    div_iter #(.DIV_ITER(DIV_ITER)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div | is_divu),
        .is_signed (is_div),
        .dividend  (rdata1),
        .divisor   (rdata2),
        .ack       (advance),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (advance) begin
            if (div_done)      {hi, lo} <= {div_rem, div_quo};
            else if (is_mult)  {hi, lo} <= prod_s;
            else if (is_multu) {hi, lo} <= prod_u;
            else begin
                if (is_mthi) hi <= rdata1;
                if (is_mtlo) lo <= rdata1;
            end
        end
    end

    assign stallreq_for_ex = (is_div | is_divu) & ~div_done;

    logic [31:0] result;
    logic        wb_we;
    logic [4:0]  wb_addr;

    assign result  = is_mfhi ? hi : (is_mflo ? lo : alu_result);
    assign wb_we   = (is_mfhi | is_mflo) ? 1'b1 : rf_we;
    assign wb_addr = (is_mfhi | is_mflo) ? inst[15:11] : rf_waddr;

    assign ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, wb_we, wb_addr, result};
    assign ex_to_id_bus    = {wb_we, wb_addr, result};
    assign is_lw           = ram_en & sel_rf_res & (ram_wen == 4'b0);
    assign data_sram_en    = ram_en;
    assign data_sram_wen   = ram_wen;
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rdata2;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, memory requests, stalls, HI/LO, mult and div timing.
module tb_ex_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   ext_stall, stall;
    logic [158:0] id_bus;
    logic [75:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_id_bus;
    logic         is_lw, data_sram_en, stallreq_for_ex;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr, data_sram_wdata;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    // a stall controller that freezes IF..MEM while EX requests it
    assign stall = stallreq_for_ex ? 6'b001111 : ext_stall;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_id_bus    (ex_to_id_bus),
        .is_lw           (is_lw),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .stallreq_for_ex (stallreq_for_ex)
    );

    task automatic chk(input string tag, input logic [75:0] got, input logic [75:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                        input logic [11:0] op, input logic [2:0] s1,
                                        input logic [3:0] s2, input logic ren,
                                        input logic [3:0] rwen, input logic we,
                                        input logic [4:0] wa, input logic srf,
                                        input logic [31:0] r1, input logic [31:0] r2);
        return {pc, inst, op, s1, s2, ren, rwen, we, wa, srf, r1, r2};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [158:0] b);
        id_bus = b;
        tick();
    endtask

    // move mfhi (fn 0x10) or mflo (fn 0x12) into EX and check the forwarded value
    task automatic chk_mf(input string tag, input logic [5:0] fn, input logic [31:0] exp);
        load(mk(32'h0, rtype(5'd0, 5'd0, 5'd10, fn), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0,
                1'b0, 5'd0, 1'b0, 32'h0, 32'h0));
        chk(tag, {38'b0, ex_to_id_bus}, {38'b0, 1'b1, 5'd10, exp});
    endtask

    // load a div/divu and count the cycles stallreq_for_ex stays high (bounded)
    task automatic run_div(input string tag, input logic [5:0] fn,
                           input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        load(mk(32'h0, rtype(5'd4, 5'd5, 5'd0, fn), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0,
                1'b0, 5'd0, 1'b0, a, b));
        while (stallreq_for_ex && n < 200) begin
            n++;
            tick();
        end
        chk(tag, 76'(n), 76'd33);
    endtask

    typedef struct packed {
        logic [11:0] op;
        logic [2:0]  s1;
        logic [3:0]  s2;
        logic [31:0] pc, inst, r1, r2, exp;
    } vec_t;

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{12'h400, 3'b001, 4'b0001, 32'h0, 32'h0, 32'd10, 32'd3, 32'd7};
        vecs[1]  = '{12'h200, 3'b001, 4'b0001, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd1};
        vecs[2]  = '{12'h100, 3'b001, 4'b0001, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'd1, 32'd0};
        vecs[3]  = '{12'h080, 3'b001, 4'b0001, 32'h0, 32'h0, 32'hF0F0, 32'hFF00, 32'hF000};
        vecs[4]  = '{12'h040, 3'b001, 4'b0001, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF};
        vecs[5]  = '{12'h020, 3'b001, 4'b0001, 32'h0, 32'h0, 32'hF0, 32'h0F, 32'hFF};
        vecs[6]  = '{12'h010, 3'b001, 4'b0001, 32'h0, 32'h0, 32'hFF, 32'h0F, 32'hF0};
        vecs[7]  = '{12'h008, 3'b100, 4'b0001, 32'h0, 32'h100, 32'h0, 32'h1, 32'h10};
        vecs[8]  = '{12'h004, 3'b100, 4'b0001, 32'h0, 32'h102, 32'h0, 32'h8000_0000, 32'h0800_0000};
        vecs[9]  = '{12'h002, 3'b100, 4'b0001, 32'h0, 32'h103, 32'h0, 32'h8000_0000, 32'hF800_0000};
        vecs[10] = '{12'h001, 3'b000, 4'b1000, 32'h0, 32'h3C01_1234, 32'h0, 32'h0, 32'h1234_0000};
        vecs[11] = '{12'h800, 3'b010, 4'b0100, 32'hBFC0_0000, 32'h0C00_0000, 32'h0, 32'h0, 32'hBFC0_0008};
        vecs[12] = '{12'h800, 3'b000, 4'b0000, 32'h0, 32'h0, 32'h1234, 32'h5678, 32'h0};

        rst = 1'b1;
        ext_stall = 6'b0;
        id_bus = '0;
        tick();
        tick();
        chk("rst_mem_bus", ex_to_mem_bus, 76'h0);
        chk("rst_id_bus", {38'b0, ex_to_id_bus}, 76'h0);
        chk("rst_sram", {38'b0, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, 76'h0);
        chk("rst_misc", {74'b0, is_lw, stallreq_for_ex}, 76'h0);
        rst = 1'b0;
        chk_mf("rst_hi", 6'h10, 32'h0);
        chk_mf("rst_lo", 6'h12, 32'h0);

        // addiu $8, $x, -1 with rs = 5
        load(mk(32'hBFC0_0000, {6'h09, 5'd1, 5'd8, 16'hFFFF}, 12'h800, 3'b001, 4'b0010,
                1'b0, 4'h0, 1'b1, 5'd8, 1'b0, 32'd5, 32'd0));
        chk("addiu_mem_bus", ex_to_mem_bus, {32'hBFC0_0000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd8, 32'd4});
        chk("addiu_id_bus", {38'b0, ex_to_id_bus}, {38'b0, 1'b1, 5'd8, 32'd4});

        // sw with base 0x100, offset 8
        load(mk(32'hBFC0_0004, {6'h2B, 5'd1, 5'd2, 16'h0008}, 12'h800, 3'b001, 4'b0010,
                1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h100, 32'hAB));
        chk("sw_sram", {38'b0, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
            {38'b0, 1'b1, 4'hF, 32'h108, 32'hAB});
        chk("sw_is_lw", {75'b0, is_lw}, 76'h0);

        for (int i = 0; i < 13; i++) begin
            load(mk(vecs[i].pc, vecs[i].inst, vecs[i].op, vecs[i].s1, vecs[i].s2, 1'b0, 4'h0,
                    1'b1, 5'd1, 1'b0, vecs[i].r1, vecs[i].r2));
            chk($sformatf("alu_%0d", i), {44'b0, ex_to_mem_bus[31:0]}, {44'b0, vecs[i].exp});
        end

        // lw $9, 4($1), then hold and then a bubble
        load(mk(32'hBFC0_0010, {6'h23, 5'd1, 5'd9, 16'h0004}, 12'h800, 3'b001, 4'b0010,
                1'b1, 4'h0, 1'b1, 5'd9, 1'b1, 32'h200, 32'h0));
        chk("lw_is_lw", {75'b0, is_lw}, 76'h1);
        chk("lw_waddr", {71'b0, ex_to_id_bus[36:32]}, 76'd9);
        ext_stall = 6'b001111;
        load('0);
        chk("hold_is_lw", {75'b0, is_lw}, 76'h1);
        ext_stall = 6'b000111;
        tick();
        chk("bubble_mem_bus", ex_to_mem_bus, 76'h0);
        chk("bubble_is_lw", {75'b0, is_lw}, 76'h0);
        ext_stall = 6'b0;

        // signed div -7 / 2
        run_div("div_cycles", 6'h1A, 32'hFFFF_FFF9, 32'd2);
        chk_mf("div_lo", 6'h12, 32'hFFFF_FFFD);
        chk_mf("div_hi", 6'h10, 32'hFFFF_FFFF);

        // divu by zero
        run_div("divz_cycles", 6'h1B, 32'h10, 32'h0);
        chk_mf("divz_lo", 6'h12, 32'hFFFF_FFFF);
        chk_mf("divz_hi", 6'h10, 32'h10);

        load(mk(32'h0, rtype(5'd4, 5'd5, 5'd0, 6'h19), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0,
                1'b0, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'd2));
        chk_mf("multu_hi", 6'h10, 32'h1);
        chk_mf("multu_lo", 6'h12, 32'hFFFF_FFFE);

        load(mk(32'h0, rtype(5'd4, 5'd5, 5'd0, 6'h18), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0,
                1'b0, 5'd0, 1'b0, 32'hFFFF_FFFD, 32'd5));
        chk_mf("mult_hi", 6'h10, 32'hFFFF_FFFF);
        chk_mf("mult_lo", 6'h12, 32'hFFFF_FFF1);

        load(mk(32'h0, rtype(5'd4, 5'd0, 5'd0, 6'h11), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0,
                1'b0, 5'd0, 1'b0, 32'h55, 32'h0));
        chk_mf("mthi_hi", 6'h10, 32'h55);

        // result ready but EX externally stalled: no relaunch while held in DONE
        run_div("divu_cycles", 6'h1B, 32'd5, 32'd2);
        ext_stall = 6'b001111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("done_hold_%0d", i), {75'b0, stallreq_for_ex}, 76'h0);
        end
        ext_stall = 6'b0;
        chk_mf("divu_lo", 6'h12, 32'd2);
        chk_mf("divu_hi", 6'h10, 32'd1);

        // reset ten cycles into a division
        load(mk(32'h0, rtype(5'd4, 5'd5, 5'd0, 6'h1B), 12'h0, 3'b0, 4'b0, 1'b0, 4'h0,
                1'b0, 5'd0, 1'b0, 32'd9, 32'd4));
        repeat (10) tick();
        chk("mid_div_stallreq", {75'b0, stallreq_for_ex}, 76'h1);
        rst = 1'b1;
        id_bus = '0;
        tick();
        chk("rst_div_stallreq", {75'b0, stallreq_for_ex}, 76'h0);
        chk("rst_div_mem_bus", ex_to_mem_bus, 76'h0);
        chk("rst_div_id_bus", {38'b0, ex_to_id_bus}, 76'h0);
        rst = 1'b0;
        chk_mf("rst_div_hi", 6'h10, 32'h0);
        chk_mf("rst_div_lo", 6'h12, 32'h0);
        run_div("after_rst_cycles", 6'h1B, 32'd100, 32'd7);
        chk_mf("after_rst_lo", 6'h12, 32'd14);
        chk_mf("after_rst_hi", 6'h10, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
